// File: rtl/ram_sp_ctrl.sv
// ram_sp_ctrl: valid/ready front end that sequences one single-port synchronous RAM.
// Define RAM_SP_CTRL_TURNAROUND_EN to insert one dead bus cycle after every read response.
//
// state   | meaning
// IDLE    | ready for a request
// WR      | write pins asserted, RAM commits at end of cycle
// RD_ADDR | read pins asserted, RAM registers the addressed word
// RD_DATA | RAM drives the bus, word captured at end of cycle
// RSP     | read response held until rsp_ready
// TURN    | dead cycle after a read response (turnaround build only)
module ram_sp_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  ram_cs_o,
  output logic                  ram_we_o,
  output logic                  ram_oe_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  inout  wire  [DATA_WIDTH-1:0] ram_data_io
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RSP     = 3'd4,
    TURN    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  accept;

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  // Pin values are computed for the state being entered, so the pins are registered
  // and line up with the state register.
  always_comb begin
    state_d     = state_q;
    cs_d        = 1'b0;
    we_d        = 1'b0;
    oe_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cs_d    = 1'b1;
          if (req_we_i) begin
            state_d = WR;
            we_d    = 1'b1;
          end else begin
            state_d = RD_ADDR;
            oe_d    = 1'b1;
          end
        end
      end
      WR: state_d = IDLE;
      RD_ADDR: begin
        state_d = RD_DATA;
        cs_d    = 1'b1;
        oe_d    = 1'b1;
      end
      RD_DATA: begin
        state_d     = RSP;
        rdata_d     = ram_data_io;
        rsp_valid_d = 1'b1;
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
`ifdef RAM_SP_CTRL_TURNAROUND_EN
          state_d = TURN;
`else
          state_d = IDLE;
`endif
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Drive only during a write; we and oe are never both set, so no contention on reads.
  assign ram_data_io = (cs_q && we_q) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign ram_cs_o    = cs_q;
  assign ram_we_o    = we_q;
  assign ram_oe_o    = oe_q;
  assign ram_addr_o  = addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Self-checking bench for ram_sp_ctrl: behavioural RAM on the bus, array reference model,
// directed scenarios plus randomized read/write traffic with random backpressure.
module tb_ram_sp_ctrl;
  localparam int DW = 8;
  localparam int AW = 8;
`ifdef RAM_SP_CTRL_TURNAROUND_EN
  localparam int TURN_GAP = 1;
`else
  localparam int TURN_GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int we_cnt = 0;
  int last_acc = 0;
  int last_hs = 0;

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ram_dout = '0;

  ram_sp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .ram_cs_o    (ram_cs),
    .ram_we_o    (ram_we),
    .ram_oe_o    (ram_oe),
    .ram_addr_o  (ram_addr),
    .ram_data_io (ram_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_we) we_cnt <= we_cnt + 1;

  // Behavioural synchronous RAM: registered read, drives the bus while cs&&oe&&!we.
  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
    if (ram_cs && ram_oe && !ram_we) ram_dout <= ram_mem[ram_addr];
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_dout : {DW{1'bz}};

  // Bus monitor
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (ram_cs && ram_we && ram_oe) begin
        fails++;
        $display("FAIL bus_ctl cs=%b we=%b oe=%b required we and oe not both high", ram_cs, ram_we, ram_oe);
      end
      if (ram_cs && ram_oe && !ram_we) begin
        checks++;
        if ($isunknown(ram_data) || ram_data !== ram_dout) begin
          fails++;
          $display("FAIL bus_read_drive data=%h required %h (RAM only driver)", ram_data, ram_dout);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    int n = 0;
    req_we = 1'b1; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin
      fails++;
      $display("FAIL %s_accept_timeout req_ready=%b required 1", tag, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    ref_mem[a] = d;
    @(negedge clk);
    req_valid = 1'b0;
    last_acc = cyc;
    checks++;
    if ({ram_cs, ram_we, ram_oe} !== 3'b110 || ram_addr !== a || ram_data !== d) begin
      fails++;
      $display("FAIL %s_wr_pins cs/we/oe=%b addr=%h data=%h required 110 %h %h",
               tag, {ram_cs, ram_we, ram_oe}, ram_addr, ram_data, a, d);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold, input string tag);
    int n = 0;
    int lat;
    logic [DW-1:0] exp_d;
    logic exp_rdy;
    req_we = 1'b0; req_addr = a; req_wdata = DW'($urandom); req_valid = 1'b1; rsp_ready = 1'b0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin
      fails++;
      $display("FAIL %s_accept_timeout req_ready=%b required 1", tag, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_d = ref_mem[a];
    @(negedge clk);
    req_valid = 1'b0;
    last_acc = cyc;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    checks++;
    if (!rsp_valid || lat != 3) begin
      fails++;
      $display("FAIL %s_latency rsp_valid=%b at cycle %0d required first high at cycle 3", tag, rsp_valid, lat);
      return;
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d || req_ready !== 1'b0 || ram_cs !== 1'b0) begin
        fails++;
        $display("FAIL %s_rsp_hold addr=%h valid=%b rdata=%h ready=%b cs=%b required 1 %h 0 0",
                 tag, a, rsp_valid, rsp_rdata, req_ready, ram_cs, exp_d);
      end
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    last_hs = cyc;
    exp_rdy = (TURN_GAP == 0);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== exp_rdy) begin
      fails++;
      $display("FAIL %s_after_handshake valid=%b req_ready=%b required 0 %b", tag, rsp_valid, req_ready, exp_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, ram_cs, ram_we, ram_oe, rsp_valid} !== 5'b0 || ram_addr !== '0 || rsp_rdata !== '0) begin
      fails++;
      $display("FAIL reset_state ready/cs/we/oe/valid=%b addr=%h rdata=%h required all zero",
               {req_ready, ram_cs, ram_we, ram_oe, rsp_valid}, ram_addr, rsp_rdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release req_ready=%b required 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int base = we_cnt;
    do_write(8'h10, 8'hA5, "t1_wr");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (we_cnt - base != 1) begin
      fails++;
      $display("FAIL t1_we_width we high for %0d cycles required 1", we_cnt - base);
    end
    do_read(8'h10, 0, "t1_rd");
  endtask

  task automatic test_back_to_back();
    int prev = 0;
    for (int a = 0; a < 256; a++) begin
      do_write(AW'(a), DW'(a) ^ 8'h5A, "t2_wr");
      if (a > 0) begin
        checks++;
        if (last_acc - prev != 2) begin
          fails++;
          $display("FAIL t2_accept_spacing addr=%0d spacing=%0d required 2", a, last_acc - prev);
        end
      end
      prev = last_acc;
    end
    for (int a = 0; a < 256; a++) do_read(AW'(a), 0, "t2_rd");
  endtask

  task automatic test_backpressure();
    do_write(8'h3C, DW'($urandom), "t3_wr");
    do_read(8'h3C, 5, "t3_rd");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    // Abort a read in RD_DATA
    req_we = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, ram_cs, ram_we, ram_oe, req_ready} !== 5'b0 || ram_addr !== '0) begin
      fails++;
      $display("FAIL t4_abort valid/cs/we/oe/ready=%b addr=%h required all zero",
               {rsp_valid, ram_cs, ram_we, ram_oe, req_ready}, ram_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL t4_idle_after_abort req_ready=%b required 1", req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL t4_no_response rsp_valid=%b required 0", rsp_valid);
      end
    end
    // Reset during WR: the registered write still lands in the RAM
    do_write(8'h77, 8'h11, "t4_wr0");
    do_write(8'h77, 8'hC3, "t4_wr1");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(8'h77, 0, "t4_rd");
  endtask

  task automatic test_read_then_write();
    int hs;
    do_write(8'h42, DW'($urandom), "t6_wr0");
    do_read(8'h42, 0, "t6_rd0");
    hs = last_hs;
    do_write(8'h43, DW'($urandom), "t6_wr1");
    checks++;
    if (last_acc - hs != 1 + TURN_GAP) begin
      fails++;
      $display("FAIL t6_turnaround write accepted %0d cycles after read handshake required %0d",
               last_acc - hs, 1 + TURN_GAP);
    end
    do_read(8'h43, 0, "t6_rd1");
    do_read(8'h42, 0, "t6_rd2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom), DW'($urandom), "rnd_wr");
      else
        do_read(AW'($urandom), int'($urandom_range(0, 3)), "rnd_rd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      ram_mem[i] = '0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_read_then_write();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
